// File: rtl/rca_serial_sub.sv
// Multi-cycle ripple-borrow subtractor: Diff = A - B - Bin, SLICE bits per clock, LSB slice first.
// Optional signed-overflow output is enabled by defining RCA_SUB_OVF_EN.
module rca_serial_sub #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef RCA_SUB_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  generate
    if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
      $error("rca_serial_sub: WIDTH must be a non-zero multiple of SLICE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic [SLICE:0]   slice_sub;

  // Operands shift right each cycle so the active slice always sits in the low bits.
  assign slice_sub = {1'b0, a_reg[SLICE-1:0]} - {1'b0, b_reg[SLICE-1:0]}
                   - {{SLICE{1'b0}}, borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      Diff      <= '0;
      Bout      <= 1'b0;
`ifdef RCA_SUB_OVF_EN
      Ovf       <= 1'b0;
`endif
      a_reg     <= '0;
      b_reg     <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= A;
            b_reg    <= B;
            borrow   <= Bin;
            cnt      <= '0;
            Diff     <= '0;
            Bout     <= 1'b0;
`ifdef RCA_SUB_OVF_EN
            Ovf      <= 1'b0;
`endif
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          Diff[int'(cnt) * SLICE +: SLICE] <= slice_sub[SLICE-1:0];
          borrow <= slice_sub[SLICE];
          a_reg  <= a_reg >> SLICE;
          b_reg  <= b_reg >> SLICE;
          if (cnt == LAST) begin
            cnt       <= '0;
            Bout      <= slice_sub[SLICE];
`ifdef RCA_SUB_OVF_EN
            // On the last slice the slice MSBs are the operand and result sign bits.
            Ovf       <= (a_reg[SLICE-1] != b_reg[SLICE-1]) &&
                         (slice_sub[SLICE-1] != a_reg[SLICE-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_serial_sub.sv
// Self-checking bench for rca_serial_sub (WIDTH=32, SLICE=4): directed vectors plus random
// operations against an arithmetic reference model; Ovf checked when RCA_SUB_OVF_EN is defined.
module tb_rca_serial_sub;

  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef RCA_SUB_OVF_EN
  logic             ovf;
`endif

  int checks   = 0;
  int failures = 0;

  rca_serial_sub #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .Bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Diff      (diff),
    .Bout      (bout)
`ifdef RCA_SUB_OVF_EN
    ,
    .Ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: full-precision subtraction; bit WIDTH of the result is the final borrow.
  function automatic logic [WIDTH:0] refSub(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                            input logic bi);
    return {1'b0, av} - {1'b0, bv} - {{WIDTH{1'b0}}, bi};
  endfunction

  function automatic logic refOvf(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                  input logic bi);
    longint s;
    s = longint'($signed(av)) - longint'($signed(bv)) - longint'(bi);
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    @(negedge clk);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    checkOutput({tag, "_latency"}, 64'(lat), 64'(N));
  endtask

  task automatic releaseResult(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_vld_drop"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic bi, input logic [WIDTH-1:0] expDiff, input logic expBout);
    applyStimulus(av, bv, bi);
    waitResult(tag);
    @(negedge clk);
    checkOutput({tag, "_diff"}, 64'(diff), 64'(expDiff));
    checkOutput({tag, "_bout"}, 64'(bout), 64'(expBout));
`ifdef RCA_SUB_OVF_EN
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(refOvf(av, bv, bi)));
`endif
    releaseResult(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rbi;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] held;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    #2 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_diff", 64'(diff), 64'd0);
    checkOutput("rst_bout", 64'(bout), 64'd0);
`ifdef RCA_SUB_OVF_EN
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
`endif
    rst_n = 1'b1;

    runOp("t1", 32'h87654321, 32'h12345678, 1'b0, 32'h7530ECA9, 1'b0);
    runOp("t2", 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1);
    runOp("t3", 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h4B4B4B4A, 1'b0);
    runOp("t4", 32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1);
`ifdef RCA_SUB_OVF_EN
    runOp("t4ovf", 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0);
    checkOutput("t4ovf_model", 64'(refOvf(32'h80000000, 32'h00000001, 1'b0)), 64'd1);
`endif

    for (int i = 0; i < 16; i++) begin
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
      rbi = 1'($urandom_range(0, 1));
      r   = refSub(ra, rb, rbi);
      runOp($sformatf("rnd%0d", i), ra, rb, rbi, r[WIDTH-1:0], r[WIDTH]);
    end

    // Backpressure: result must hold while in_valid is asserted with new operands.
    applyStimulus(32'h87654321, 32'h12345678, 1'b0);
    waitResult("t5");
    held = diff;
    checkOutput("t5_diff", 64'(held), 64'h7530ECA9);
    @(negedge clk);
    a        = 32'hDEADBEEF;
    b        = 32'h01234567;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_hold_diff%0d", k), 64'(diff), 64'(held));
      checkOutput($sformatf("t5_hold_vld%0d", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("t5_hold_rdy%0d", k), 64'(in_ready), 64'd0);
    end
    checkOutput("t5_hold_bout", 64'(bout), 64'd0);
    in_valid = 1'b0;
    releaseResult("t5");
    repeat (3) @(negedge clk);
    checkOutput("t5_no_capture", 64'(in_ready), 64'd1);
    checkOutput("t5_diff_kept", 64'(diff), 64'(held));

    // Reset in the middle of RUN aborts the operation at once.
    applyStimulus(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t6_running", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_vld", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_diff", 64'(diff), 64'd0);
    checkOutput("t6_rst_rdy", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runOp("t6_after", 32'h87654321, 32'h12345678, 1'b0, 32'h7530ECA9, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
